frame_sequencer: RTL and testbench
==================================

# frame_sequencer

Per-frame sequencer for the dark-detection line buffer path. Tracks active lines from the incoming video timing and generates the signals the line buffer consumes: the registered `de`, the last-active-line flag and a one-cycle freeze strobe. After each freeze it samples the buffer's majority vote. The vote is committed only at the next vertical sync and only if that frame had a valid line count; committed votes pass through a hysteresis FSM that drives the global dark-mode flag.

## Interface

Parameters:
- `V_ACT`, 1080: active lines per frame; must be ≥ 2.
- `HOLD`, 4: consecutive agreeing frames required to flip `dark_o`; must be ≥ 1.
- `SAMPLE_LAT`, 2: cycles from `freeze_o` to a valid `rx_i`; must be ≥ 1.
- `LW`, `$clog2(V_ACT+1)`: line counter width.

Ports:
- `clk_i` input 1: pixel clock.
- `rst_i` input 1: asynchronous, active-high reset.
- `vs_i` input 1: vertical sync, active-high, level.
- `de_i` input 1: data enable.
- `rx_i` input 1: majority vote from the line buffer.
- `de_r_o` output 1: `de_i` delayed 1 cycle.
- `vp_last_o` output 1: high while the current line is line `V_ACT-1`.
- `freeze_o` output 1: one-cycle strobe that freezes the line buffer.
- `line_o` output LW: completed-line count in the current frame.
- `dark_o` output 1: committed dark-mode decision.
- `commit_o` output 1: one-cycle strobe; a vote was committed this cycle.
- `err_o` output 1: one-cycle strobe; frame ended with `line_o != V_ACT`.

## Operation

- Edge detection: `vs_r` and `de_r_o` are registered copies of the inputs.
  - `vs_rise = vs_i & ~vs_r`.
  - `de_fall = ~de_i & de_r_o`.
- Line counter:
  - Cleared to 0 on `vs_rise`.
  - Otherwise increments on `de_fall`.
  - Saturates at `2^LW-1`; no wrap.
- Last-line flag: `vp_last_o = (line_o == V_ACT-1)`, combinational from the counter.
- Freeze strobe: `freeze_o = vp_last_o & de_fall`, registered so it appears 1 cycle after the falling edge.
  - At most one freeze per frame; a second qualifying edge in the same frame is suppressed by a `frozen` flag, which `vs_rise` clears.
- Sample shift register: `freeze_o` enters a SAMPLE_LAT-deep pipeline. When the strobe exits, `rx_i` is latched into `pend_vote` and `pend_valid` is set.
- Commit, on `vs_rise`:
  - If `pend_valid` and the line count before clearing equals `V_ACT`: commit `pend_vote` to the FSM and pulse `commit_o`.
  - Otherwise: discard the vote and pulse `err_o`.
  - In both cases `pend_valid` is cleared.
  - The first `vs_rise` after reset is ignored: no commit, no error.
- Hysteresis FSM (states `LIGHT`, `ARM_DARK`, `DARK`, `ARM_LIGHT`), evaluated only on commit; `hold_cnt` counts agreeing votes:
  - `LIGHT`: vote=1 → `ARM_DARK` with `hold_cnt=1`, or directly to `DARK` if HOLD=1. vote=0 → stay.
  - `ARM_DARK`: vote=1 → `hold_cnt++`; when it reaches HOLD → `DARK`. vote=0 → `LIGHT`, `hold_cnt=0`.
  - `DARK` / `ARM_LIGHT`: mirror image with vote=0.
  - `dark_o` is 1 in `DARK` and `ARM_LIGHT`.
- Simultaneous events:
  - `vs_rise` in the same cycle as the sample-pipeline exit: the sample is treated as belonging to the old frame. It is committed if the line count is valid.
  - `vs_rise` while the freeze pipeline is still in flight: the pipeline is flushed and the vote is discarded with `err_o`.

## Timing

- Reset values: all outputs 0, FSM in `LIGHT`, counters, `pend_*`, `frozen` and pipeline all 0, first-vs flag set.
- `de_r_o`: 1-cycle latency.
- `line_o`: updates in the cycle after `de_fall`.
- `freeze_o`: high for exactly 1 cycle, 2 cycles after the last active pixel of line `V_ACT-1`.
- `rx_i`: sampled `SAMPLE_LAT` cycles after `freeze_o`.
- `commit_o`, `err_o` and the `dark_o` change: all 1 cycle after the `vs_i` rising edge.
- Reset asserted mid-frame: everything returns to reset values immediately; the next frame is treated as the first.

## Structure

- Shared package: FSM state enum `fs_state_t` and the default `HOLD`/`SAMPLE_LAT` constants, shared with the line buffer instance parameters.
- One sub-module, `dark_hysteresis`: the FSM plus `hold_cnt`, with inputs `commit`/`vote` and output `dark`. Line counting, freeze generation and the sample pipeline stay in the top level.

## Test plan

- V_ACT=4, HOLD=2: four frames of 4 lines with `rx_i=1`. The first vs is ignored; `dark_o` rises 1 cycle after the 3rd vs rise, with `commit_o` pulsing on each of those edges.
- Frame with 3 lines (V_ACT=4): no `freeze_o`, `err_o` pulses at the next vs, and the FSM state is unchanged.
- 4 valid lines plus a 5th `de` burst: exactly one `freeze_o`; `line_o=5` at vs, so `err_o` pulses and the vote is discarded.
- While in `DARK`, alternating votes 0,1,0,1: `dark_o` stays 1 and the state oscillates between `ARM_LIGHT` and `DARK`.
- `vs_i` rises 1 cycle after `freeze_o` with SAMPLE_LAT=2: pipeline flushed, `err_o` pulses, no commit.
- `rst_i` asserted mid-line on line 2: all outputs 0 asynchronously. After release, the first vs produces no commit and no error.

Source files
------------

// File: rtl/frame_sequencer_pkg.sv
// Shared definitions for the dark-detection frame sequencer and the line
// buffer instance parameters.
//   fs_state_t      : hysteresis FSM state encoding
//   HOLD_DEF        : default agreeing-frame count before dark_o flips
//   SAMPLE_LAT_DEF  : default freeze-to-vote latency of the line buffer
package frame_sequencer_pkg;

  typedef enum logic [1:0] {
    LIGHT     = 2'd0,
    ARM_DARK  = 2'd1,
    DARK      = 2'd2,
    ARM_LIGHT = 2'd3
  } fs_state_t;

  localparam int HOLD_DEF       = 4;
  localparam int SAMPLE_LAT_DEF = 2;

endpackage

// File: rtl/dark_hysteresis.sv
// Hysteresis on committed per-frame votes. dark flips only after HOLD
// consecutive committed votes disagree with the current decision; a single
// agreeing vote cancels a pending flip.
//   clk_i, rst_i : clock, async active-high reset
//   commit       : one-cycle strobe, vote is valid
//   vote         : committed majority vote (1 = dark)
//   dark         : registered dark-mode decision
module dark_hysteresis
  import frame_sequencer_pkg::*;
#(
  parameter int HOLD = HOLD_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic commit,
  input  logic vote,
  output logic dark
);

  localparam int HW = $clog2(HOLD + 1);
  localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD - 1);

  fs_state_t     state;
  logic [HW-1:0] hold_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= LIGHT;
      hold_cnt <= '0;
      dark     <= 1'b0;
    end else if (commit) begin
      case (state)
        LIGHT: if (vote) begin
          if (HOLD == 1) begin
            state <= DARK;
            dark  <= 1'b1;
          end else begin
            state    <= ARM_DARK;
            hold_cnt <= HW'(1);
          end
        end
        ARM_DARK: if (vote) begin
          // hold_cnt already counts this streak; this vote completes it
          if (hold_cnt == HOLD_M1) begin
            state    <= DARK;
            dark     <= 1'b1;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end else begin
          state    <= LIGHT;
          hold_cnt <= '0;
        end
        DARK: if (!vote) begin
          if (HOLD == 1) begin
            state <= LIGHT;
            dark  <= 1'b0;
          end else begin
            state    <= ARM_LIGHT;
            hold_cnt <= HW'(1);
          end
        end
        ARM_LIGHT: if (!vote) begin
          if (hold_cnt == HOLD_M1) begin
            state    <= LIGHT;
            dark     <= 1'b0;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end else begin
          state    <= DARK;
          hold_cnt <= '0;
        end
        default: begin
          state    <= LIGHT;
          hold_cnt <= '0;
          dark     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame sequencer for the dark-detection line buffer path.
// Counts active lines, freezes the line buffer once after line V_ACT-1,
// samples its majority vote SAMPLE_LAT cycles later and commits that vote at
// the next vertical sync when the frame had exactly V_ACT lines.
//   clk_i, rst_i : pixel clock, async active-high reset
//   vs_i, de_i   : video timing (vsync level, data enable)
//   rx_i         : majority vote from the line buffer
//   de_r_o       : de_i delayed one cycle
//   vp_last_o    : current line is line V_ACT-1
//   freeze_o     : one-cycle line buffer freeze strobe
//   line_o       : completed lines in the current frame (saturating)
//   dark_o       : committed dark-mode decision
//   commit_o     : one-cycle strobe, a vote was committed
//   err_o        : one-cycle strobe, frame ended without a usable vote
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int V_ACT      = 1080,
  parameter int HOLD       = HOLD_DEF,
  parameter int SAMPLE_LAT = SAMPLE_LAT_DEF,
  parameter int LW         = $clog2(V_ACT + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          vs_i,
  input  logic          de_i,
  input  logic          rx_i,
  output logic          de_r_o,
  output logic          vp_last_o,
  output logic          freeze_o,
  output logic [LW-1:0] line_o,
  output logic          dark_o,
  output logic          commit_o,
  output logic          err_o
);

  localparam logic [LW-1:0] LINE_MAX = '1;
  localparam logic [LW-1:0] V_LAST   = LW'(V_ACT - 1);
  localparam logic [LW-1:0] V_FULL   = LW'(V_ACT);

  logic                  vs_r;
  logic                  vs_rise, de_fall;
  logic                  frozen, frz_set;
  logic                  first_vs;
  logic                  pend_valid, pend_vote;
  logic                  smp_exit, frame_ok, commit_now, vote_now;
  // vld_pipe[0] is the freeze strobe itself; bit SAMPLE_LAT marks the cycle
  // in which rx_i carries the vote.
  logic [SAMPLE_LAT:0]   vld_pipe;

  assign vs_rise   = vs_i & ~vs_r;
  assign de_fall   = ~de_i & de_r_o;
  assign vp_last_o = (line_o == V_LAST);
  assign freeze_o  = vld_pipe[0];
  assign smp_exit  = vld_pipe[SAMPLE_LAT];

  // A frame boundary never starts a new freeze; it belongs to neither frame.
  assign frz_set = vp_last_o & de_fall & ~frozen & ~vs_rise;

  // A sample exiting on the vs_rise cycle still belongs to the old frame.
  // A sample still in flight leaves both terms low, so it ends as an error.
  assign frame_ok   = (pend_valid | smp_exit) && (line_o == V_FULL);
  assign vote_now   = smp_exit ? rx_i : pend_vote;
  assign commit_now = vs_rise & ~first_vs & frame_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vs_r       <= 1'b0;
      de_r_o     <= 1'b0;
      line_o     <= '0;
      frozen     <= 1'b0;
      vld_pipe   <= '0;
      pend_valid <= 1'b0;
      pend_vote  <= 1'b0;
      first_vs   <= 1'b1;
      commit_o   <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      vs_r     <= vs_i;
      de_r_o   <= de_i;
      commit_o <= commit_now;
      err_o    <= vs_rise & ~first_vs & ~frame_ok;

      if (vs_rise) begin
        line_o     <= '0;
        frozen     <= 1'b0;
        vld_pipe   <= '0;
        pend_valid <= 1'b0;
        first_vs   <= 1'b0;
      end else begin
        if (de_fall && line_o != LINE_MAX)
          line_o <= line_o + 1'b1;
        if (frz_set)
          frozen <= 1'b1;
        vld_pipe <= {vld_pipe[SAMPLE_LAT-1:0], frz_set};
        if (smp_exit) begin
          pend_vote  <= rx_i;
          pend_valid <= 1'b1;
        end
      end
    end
  end

  dark_hysteresis #(.HOLD(HOLD)) u_hyst (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .commit (commit_now),
    .vote   (vote_now),
    .dark   (dark_o)
  );

endmodule

// File: tb/tb_frame_sequencer.sv
module tb_frame_sequencer;
  import frame_sequencer_pkg::*;

  localparam int V_ACT = 4;
  localparam int HOLD  = 2;
  localparam int SL    = 2;
  localparam int LW    = $clog2(V_ACT + 1);
  localparam int LMAX  = (1 << LW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          vs_i = 1'b0, de_i = 1'b0, rx_i = 1'b0;
  logic          de_r_o, vp_last_o, freeze_o, dark_o, commit_o, err_o;
  logic [LW-1:0] line_o;

  int passed = 0;
  int total  = 0;

  // frame-level reference: first-vs flag, decision, length of disagreeing streak
  bit m_first;
  bit m_dark;
  int m_streak;

  frame_sequencer #(.V_ACT(V_ACT), .HOLD(HOLD), .SAMPLE_LAT(SL)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .vs_i(vs_i), .de_i(de_i), .rx_i(rx_i),
    .de_r_o(de_r_o), .vp_last_o(vp_last_o), .freeze_o(freeze_o),
    .line_o(line_o), .dark_o(dark_o), .commit_o(commit_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  function automatic fs_state_t m_state();
    if (m_dark) return (m_streak > 0) ? ARM_LIGHT : DARK;
    return (m_streak > 0) ? ARM_DARK : LIGHT;
  endfunction

  task automatic m_reset();
    m_first  = 1'b1;
    m_dark   = 1'b0;
    m_streak = 0;
  endtask

  task automatic m_vs(input bit valid, input bit vote, output bit ec, output bit ee);
    ec = 1'b0;
    ee = 1'b0;
    if (m_first) m_first = 1'b0;
    else if (valid) begin
      ec = 1'b1;
      if (vote != m_dark) begin
        m_streak++;
        if (m_streak == HOLD) begin
          m_dark   = vote;
          m_streak = 0;
        end
      end else m_streak = 0;
    end else ee = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_de_r"}, de_r_o, 0);
    chk({tag, "_vp_last"}, vp_last_o, 0);
    chk({tag, "_freeze"}, freeze_o, 0);
    chk({tag, "_line"}, line_o, 0);
    chk({tag, "_dark"}, dark_o, 0);
    chk({tag, "_commit"}, commit_o, 0);
    chk({tag, "_err"}, err_o, 0);
  endtask

  // vsync edge; 'already' means the caller raised vs_i before the edge
  task automatic do_vs(input bit already, input bit valid, input bit vote);
    bit ec, ee;
    if (!already) vs_i = 1'b1;
    step();
    m_vs(valid, vote, ec, ee);
    chk("commit", commit_o, ec);
    chk("err", err_o, ee);
    chk("dark", dark_o, m_dark);
    chk("state", 32'(dut.u_hyst.state), 32'(m_state()));
    chk("line_clr", line_o, 0);
    step();
    chk("commit_strobe", commit_o, 0);
    chk("err_strobe", err_o, 0);
    vs_i = 1'b0;
    rx_i = 1'($urandom);
    repeat (2) step();
  endtask

  // mode 0: normal; 1: vs one cycle after freeze; 2: vs on the sample cycle.
  // rx_i carries the vote only on its sampling cycle, the inverse elsewhere.
  task automatic frame(input int nl, input bit vote, input int mode);
    for (int i = 0; i < nl; i++) begin
      de_i = 1'b1;
      rx_i = ~vote;
      step();
      chk("de_r", de_r_o, 1);
      repeat ($urandom_range(2, 6)) step();
      de_i = 1'b0;
      step();
      chk("line_cnt", line_o, (i + 1 > LMAX) ? LMAX : i + 1);
      chk("vp_last", vp_last_o, 32'(i + 1 == V_ACT - 1));
      chk("freeze", freeze_o, 32'(i == V_ACT - 1));
      if (i == V_ACT - 1) begin
        for (int k = 2; k <= SL + 3; k++) begin
          step();
          if (k == 2) chk("freeze_once", freeze_o, 0);
          if (mode == 1 && k == 2) begin
            vs_i = 1'b1;
            return;
          end
          rx_i = (k == SL + 1) ? vote : ~vote;
          if (mode == 2 && k == SL + 1) begin
            vs_i = 1'b1;
            return;
          end
        end
      end else begin
        repeat ($urandom_range(2, 4)) step();
      end
    end
    repeat (2) step();
  endtask

  initial begin
    int r, nl, mode;
    bit vote;

    #1 rst_i = 1'b1;
    m_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk_reset_outputs("reset");
    chk("reset_state", 32'(dut.u_hyst.state), 32'(LIGHT));
    rst_i = 1'b0;
    step();

    // first vs ignored, then four valid dark frames
    do_vs(1'b0, 1'b0, 1'b0);
    for (int f = 0; f < 4; f++) begin
      frame(V_ACT, 1'b1, 0);
      do_vs(1'b0, 1'b1, 1'b1);
    end

    // short frame, then long frame with a discarded light vote
    frame(V_ACT - 1, 1'b0, 0);
    do_vs(1'b0, 1'b0, 1'b0);
    frame(V_ACT + 1, 1'b0, 0);
    do_vs(1'b0, 1'b0, 1'b0);

    // alternating votes while dark
    for (int f = 0; f < 4; f++) begin
      vote = f[0];
      frame(V_ACT, vote, 0);
      do_vs(1'b0, 1'b1, vote);
    end

    // vs while the sample is in flight, then vs on the sample cycle
    frame(V_ACT, 1'b0, 1);
    do_vs(1'b1, 1'b0, 1'b0);
    frame(V_ACT, 1'b0, 2);
    do_vs(1'b1, 1'b1, 1'b0);

    // randomized frames
    for (int f = 0; f < 14; f++) begin
      r    = int'($urandom_range(0, 5));
      nl   = (r < 4) ? V_ACT : ((r == 4) ? V_ACT - 1 : V_ACT + 1);
      vote = 1'($urandom);
      mode = (nl == V_ACT) ? int'($urandom_range(0, 2)) : 0;
      frame(nl, vote, mode);
      do_vs(mode != 0, (nl == V_ACT) && (mode != 1), vote);
    end

    // force dark, then reset in the middle of line 2
    for (int f = 0; f <= HOLD; f++) begin
      frame(V_ACT, 1'b1, 0);
      do_vs(1'b0, 1'b1, 1'b1);
    end
    de_i = 1'b1;
    repeat (3) step();
    de_i = 1'b0;
    repeat (3) step();
    de_i = 1'b1;
    repeat (2) step();
    chk("pre_rst_line", line_o, 1);
    chk("pre_rst_dark", dark_o, m_dark);
    #2 rst_i = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    de_i = 1'b0;
    repeat (2) step();
    rst_i = 1'b0;
    m_reset();
    step();
    do_vs(1'b0, 1'b0, 1'b0);
    frame(V_ACT, 1'b1, 0);
    do_vs(1'b0, 1'b1, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
